// File: rtl/bch_128_enc.sv
// Systematic shortened BCH(144,128) t=2 encoder, one codeword per clock.
// Parity is (D(x) * x^16) mod g(x), g = 0x16F63, computed in one cycle.
module bch_128_enc (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic [0:127] i_data,
    output logic [0:143] o_code,
    output logic         o_valid
);

    // g(x) without its implicit x^16 term
    localparam logic [15:0] GEN_LOW = 16'h6F63;

    logic [15:0] parity;

    // Fully unrolled LFSR division, highest-degree message bit first
    always_comb begin
        parity = '0;
        for (int i = 0; i < 128; i++) begin
            if (i_data[i] ^ parity[15]) begin
                parity = {parity[14:0], 1'b0} ^ GEN_LOW;
            end else begin
                parity = {parity[14:0], 1'b0};
            end
        end
    end

    // reset_n is active-high despite its name
    always_ff @(posedge clk) begin
        if (reset_n) begin
            o_code  <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= enable;
            if (enable) begin
                o_code <= {i_data, parity};
            end
        end
    end

endmodule

// File: tb/tb_bch_128_enc.sv
// Self-checking bench for bch_128_enc: directed vector table plus
// randomized traffic against a polynomial long-division model.
module tb_bch_128_enc;

    logic         clk;
    logic         reset_n;
    logic         enable;
    logic [0:127] i_data;
    logic [0:143] o_code;
    logic         o_valid;

    int checks = 0;
    int errors = 0;

    bch_128_enc dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .i_data  (i_data),
        .o_code  (o_code),
        .o_valid (o_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         en;
        logic [127:0] data;
        logic [143:0] code;
        logic         valid;
    } vec_t;

    // Remainder of a 144-bit polynomial (bit k = x^k) divided by g(x)
    function automatic logic [15:0] mod_g(input logic [143:0] p);
        logic [143:0] v;
        logic [143:0] g;
        v = p;
        for (int k = 143; k >= 16; k--) begin
            if (v[k]) begin
                g = 144'h16F63;
                v = v ^ (g << (k - 16));
            end
        end
        return v[15:0];
    endfunction

    function automatic logic [143:0] model(input logic [127:0] d);
        logic [143:0] shifted;
        shifted = {d, 16'h0};
        return {d, mod_g(shifted)};
    endfunction

    task automatic check(input string name, input logic [143:0] got,
                         input logic [143:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic drive(input logic rst, input logic en,
                         input logic [127:0] d);
        @(negedge clk);
        reset_n = rst;
        enable  = en;
        i_data  = d;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [12];

    initial begin
        logic [143:0] exp_code;
        logic [143:0] got;
        logic [127:0] d;
        logic         en;

        reset_n = 1'b1;
        enable  = 1'b0;
        i_data  = '0;

        tbl[0]  = '{1'b1, 1'b1, 128'h9, 144'h0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 128'h0, 144'h0, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 128'h1, {128'h1, 16'h6F63}, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 128'h2, {128'h2, 16'hDEC6}, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 128'h4, {128'h4, 16'hD2EF}, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 128'h3, {128'h3, 16'hB1A5}, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 128'hDEAD, {128'h3, 16'hB1A5}, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 128'hBEEF, {128'h3, 16'hB1A5}, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 128'h1, {128'h1, 16'h6F63}, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 128'h4, 144'h0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 128'h4, {128'h4, 16'hD2EF}, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 128'h2, {128'h2, 16'hDEC6}, 1'b1};

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].data);
            got = o_code;
            check($sformatf("vec%0d_code", i), got, tbl[i].code);
            check($sformatf("vec%0d_valid", i), {143'h0, o_valid},
                  {143'h0, tbl[i].valid});
        end

        // Mid-stream reset with enable high, then resume
        drive(1'b0, 1'b1, 128'h5);
        drive(1'b1, 1'b1, 128'h7);
        got = o_code;
        check("midrst_code", got, 144'h0);
        check("midrst_valid", {143'h0, o_valid}, 144'h0);
        drive(1'b0, 1'b1, 128'h7);
        got = o_code;
        check("resume_code", got, model(128'h7));
        check("resume_valid", {143'h0, o_valid}, 144'h1);
        exp_code = got;

        // Random traffic with occasional idle cycles
        exp_code = model(128'h7);
        for (int n = 0; n < 1200; n++) begin
            d  = {$urandom, $urandom, $urandom, $urandom};
            en = ($urandom_range(0, 7) != 0);
            drive(1'b0, en, d);
            if (en) exp_code = model(d);
            got = o_code;
            check("rand_code", got, exp_code);
            check("rand_valid", {143'h0, o_valid}, {143'h0, en});
            if (en) begin
                check("rand_sys", {16'h0, got[143:16]}, {16'h0, d});
                check("rand_div", {128'h0, mod_g(got)}, 144'h0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bch_128_enc.md
BCH_128_ENC -- requirements
Module: bch_128_enc

Interface
REQ-001 Parameters: none; all widths and the generator polynomial are fixed.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  synchronous, active-high reset (asserted when 1, sampled on clk rising edge only).
REQ-004 enable  input  1  encode request, sampled each rising edge.
REQ-005 i_data  input  128  message, declared [0:127]; bit 0 = highest-degree coefficient (x^127), bit 127 = x^0.
REQ-006 o_code  output  144  registered codeword, declared [0:143]; bit 0 = x^143, bit 143 = x^0.
REQ-007 o_valid  output  1  registered; 1 = o_code holds the codeword of the message sampled on the previous edge.

Function
REQ-008 Code: shortened binary BCH (144,128), t=2, derived from BCH(255,239) over GF(2^8).
REQ-009 Generator g(x) = x^16+x^14+x^13+x^11+x^10+x^9+x^8+x^6+x^5+x+1 (0x16F63) = (x^8+x^4+x^3+x^2+1)(x^8+x^6+x^5+x^4+x^2+x+1).
REQ-010 Systematic: o_code[0:127] = i_data[0:127]; o_code[128:143] = parity P.
REQ-011 P(x) = (D(x)*x^16) mod g(x) over GF(2); o_code[128] = coefficient of x^15, o_code[143] = coefficient of x^0.
REQ-012 Every produced codeword polynomial is divisible by g(x).
REQ-013 Parity is computed combinationally within one cycle (unrolled LFSR or XOR matrix); no multi-cycle iteration.
REQ-014 Latency: if enable=1 at edge N (reset deasserted), o_code gets the codeword of i_data sampled at edge N and o_valid=1 after edge N.
REQ-015 Throughput: one new message per cycle; back-to-back enables produce back-to-back valid codewords, each with 1-cycle latency.
REQ-016 If enable=0 at an edge: o_valid=0 after that edge; o_code holds its previous value.
REQ-017 i_data is ignored while enable=0; no internal state other than o_code and o_valid.
REQ-018 Encoder is linear: code(a XOR b) = code(a) XOR code(b); code(0) = 0.

Reset
REQ-019 reset_n=1 at an edge forces o_code = 144'h0 and o_valid = 0 after that edge.
REQ-020 Reset takes priority over enable; an encode request on a reset edge is discarded.
REQ-021 Reset mid-stream: first edge with reset_n=0 and enable=1 produces a normal codeword (o_valid=1) after that edge.
REQ-022 Before the first reset, output values are undefined; the bench applies reset first.

Verification
REQ-023 reset_n=1 for 1 edge, enable=1 -> o_code=0, o_valid=0; then reset_n=0, enable=1, i_data=0 -> after next edge o_code=0, o_valid=1.
REQ-024 i_data=128'h1, enable=1 -> next cycle o_code = {128'h1, 16'h6F63}, o_valid=1.
REQ-025 Back-to-back i_data=128'h2, 128'h4, 128'h3 on consecutive edges -> parities 16'hDEC6, 16'hD2EF, 16'hB1A5 on consecutive cycles, o_valid=1 each cycle.
REQ-026 After a valid cycle, enable=0 with i_data changing -> o_valid=0, o_code unchanged.
REQ-027 Random i_data (>=1000 vectors) -> o_code[0:127]=i_data, codeword mod g(x) = 0, parity matches a reference model.
REQ-028 Assert reset_n=1 while enable=1 mid-stream -> o_code=0, o_valid=0 on the next cycle; encoding resumes on the first edge after release.
